// File: rtl/wb_pipe_pkg.sv
// Shared types for the MEM/WB pipeline register: stage entry layout, the XZR
// register number and the write-back data select.
package wb_pipe_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int REG_W_DEF  = 5;

   localparam logic [REG_W_DEF-1:0] ZERO_REG = 5'd31;

   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      logic                  mem_to_reg;
      logic [REG_W_DEF-1:0]  rd;
      logic [DATA_W_DEF-1:0] mem_data;
      logic [DATA_W_DEF-1:0] alu_result;
   } entry_t;

   function automatic logic [DATA_W_DEF-1:0] sel_data(input entry_t e);
      return e.mem_to_reg ? e.mem_data : e.alu_result;
   endfunction

endpackage

// File: rtl/wb_pipe_stage.sv
// One MEM/WB entry register. Priority on each edge: reset, flush, stall, load.
module wb_pipe_stage
   import wb_pipe_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   flush,
   input  logic   stall,
   input  entry_t d,
   output entry_t q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (flush) begin
         q <= '0;
      end else if (!stall) begin
         q <= d;
      end
   end

endmodule

// File: rtl/wb_pipe_fwd.sv
// DEPTH-stage MEM/WB pipeline register with youngest-writer forwarding lookups
// and a retired-entry counter. DATA_W/REG_W must not exceed the package widths.
module wb_pipe_fwd
   import wb_pipe_pkg::*;
#(
   parameter int DEPTH  = 1,
   parameter int DATA_W = 64,
   parameter int REG_W  = 5,
   parameter int NSRC   = 2,
   parameter int CNT_W  = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   flush,
   input  logic                   valid_in,
   input  logic                   reg_write_in,
   input  logic                   mem_to_reg_in,
   input  logic [REG_W-1:0]       rd_in,
   input  logic [DATA_W-1:0]      mem_data_in,
   input  logic [DATA_W-1:0]      alu_result_in,
   output logic                   valid_wb,
   output logic                   reg_write_wb,
   output logic                   mem_to_reg_wb,
   output logic [REG_W-1:0]       rd_wb,
   output logic [DATA_W-1:0]      mem_data_wb,
   output logic [DATA_W-1:0]      alu_result_wb,
   output logic [DATA_W-1:0]      wb_data,
   input  logic [NSRC*REG_W-1:0]  src_rd,
   output logic [NSRC-1:0]        fwd_hit,
   output logic [NSRC*DATA_W-1:0] fwd_data,
   output logic [CNT_W-1:0]       retire_cnt
);

   entry_t                in_entry;
   entry_t                stage_q   [DEPTH];
   logic [DATA_W_DEF-1:0] stage_sel [DEPTH];
   entry_t                last;

   // reg_write is qualified with valid so a bubble can never be a forwarding source.
   always_comb begin
      in_entry            = '0;
      in_entry.valid      = valid_in;
      in_entry.reg_write  = reg_write_in & valid_in;
      in_entry.mem_to_reg = mem_to_reg_in;
      in_entry.rd         = REG_W_DEF'(rd_in);
      in_entry.mem_data   = DATA_W_DEF'(mem_data_in);
      in_entry.alu_result = DATA_W_DEF'(alu_result_in);
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_first
         wb_pipe_stage u_stage (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .stall (stall),
            .d     (in_entry),
            .q     (stage_q[k])
         );
      end else begin : g_next
         wb_pipe_stage u_stage (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .stall (stall),
            .d     (stage_q[k-1]),
            .q     (stage_q[k])
         );
      end
      assign stage_sel[k] = sel_data(stage_q[k]);
   end

   assign last          = stage_q[DEPTH-1];
   assign valid_wb      = last.valid;
   assign reg_write_wb  = last.reg_write;
   assign mem_to_reg_wb = last.mem_to_reg;
   assign rd_wb         = last.rd[REG_W-1:0];
   assign mem_data_wb   = last.mem_data[DATA_W-1:0];
   assign alu_result_wb = last.alu_result[DATA_W-1:0];
   assign wb_data       = stage_sel[DEPTH-1][DATA_W-1:0];

   // Scan oldest to youngest so the youngest eligible stage overwrites the result.
   always_comb begin
      fwd_hit  = '0;
      fwd_data = '0;
      for (int i = 0; i < NSRC; i++) begin
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (stage_q[k].valid && stage_q[k].reg_write &&
                stage_q[k].rd != ZERO_REG &&
                stage_q[k].rd == REG_W_DEF'(src_rd[i*REG_W +: REG_W])) begin
               fwd_hit[i]                    = 1'b1;
               fwd_data[i*DATA_W +: DATA_W]  = stage_sel[k][DATA_W-1:0];
            end
         end
      end
   end

   // The last-stage entry commits when it leaves, and a flush still lets it leave.
   always_ff @(posedge clk) begin
      if (reset) begin
         retire_cnt <= '0;
      end else if (valid_wb && (!stall || flush)) begin
         retire_cnt <= retire_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_wb_pipe_fwd.sv
// Bench for wb_pipe_fwd: DEPTH 1, 2 and 3 instances share inputs and are
// checked against a shift-array reference model, a vector table and directed cases.
module tb_wb_pipe_fwd;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic        valid_in, reg_write_in, mem_to_reg_in;
   logic [4:0]  rd_in;
   logic [63:0] mem_data_in, alu_result_in;
   logic [9:0]  src_rd;

   logic [2:0]         valid_o, rw_o, m2r_o;
   logic [2:0][4:0]    rd_o;
   logic [2:0][63:0]   mem_o, alu_o, wb_o;
   logic [2:0][1:0]    hit_o;
   logic [2:0][127:0]  fdat_o;
   logic [2:0][31:0]   cnt_o;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   for (genvar j = 0; j < 3; j++) begin : g_dut
      wb_pipe_fwd #(.DEPTH(j + 1)) dut (
         .clk           (clk),
         .reset         (reset),
         .stall         (stall),
         .flush         (flush),
         .valid_in      (valid_in),
         .reg_write_in  (reg_write_in),
         .mem_to_reg_in (mem_to_reg_in),
         .rd_in         (rd_in),
         .mem_data_in   (mem_data_in),
         .alu_result_in (alu_result_in),
         .valid_wb      (valid_o[j]),
         .reg_write_wb  (rw_o[j]),
         .mem_to_reg_wb (m2r_o[j]),
         .rd_wb         (rd_o[j]),
         .mem_data_wb   (mem_o[j]),
         .alu_result_wb (alu_o[j]),
         .wb_data       (wb_o[j]),
         .src_rd        (src_rd),
         .fwd_hit       (hit_o[j]),
         .fwd_data      (fdat_o[j]),
         .retire_cnt    (cnt_o[j])
      );
   end

   // Reference model: index 0 is the youngest entry of each pipe.
   typedef struct packed {
      logic        valid, rw, m2r;
      logic [4:0]  rd;
      logic [63:0] mem, alu;
   } ment_t;

   ment_t       mp   [3][4];
   logic [31:0] mcnt [3];

   typedef struct {
      logic        rst, stl, fls, v, rw, m2r;
      logic [4:0]  rd;
      logic [63:0] mem, alu;
      logic        ev;
      logic [4:0]  erd;
      logic [63:0] ewb;
      logic [31:0] ecnt;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_step();
      for (int j = 0; j < 3; j++) begin
         int d;
         d = j + 1;
         if (reset) begin
            for (int k = 0; k < 4; k++) mp[j][k] = '0;
            mcnt[j] = 0;
         end else begin
            if (mp[j][d-1].valid && (!stall || flush)) mcnt[j] = mcnt[j] + 1;
            if (flush) begin
               for (int k = 0; k < 4; k++) mp[j][k] = '0;
            end else if (!stall) begin
               for (int k = d - 1; k > 0; k--) mp[j][k] = mp[j][k-1];
               mp[j][0].valid = valid_in;
               mp[j][0].rw    = reg_write_in & valid_in;
               mp[j][0].m2r   = mem_to_reg_in;
               mp[j][0].rd    = rd_in;
               mp[j][0].mem   = mem_data_in;
               mp[j][0].alu   = alu_result_in;
            end
         end
      end
   endtask

   task automatic check_all();
      for (int j = 0; j < 3; j++) begin
         ment_t        l;
         logic [63:0]  ewb;
         logic [1:0]   eh;
         logic [127:0] ed;
         l   = mp[j][j];
         ewb = l.m2r ? l.mem : l.alu;
         eh  = '0;
         ed  = '0;
         for (int i = 0; i < 2; i++) begin
            logic [4:0] s;
            s = src_rd[i*5 +: 5];
            for (int k = 0; k <= j; k++) begin
               if (!eh[i] && mp[j][k].valid && mp[j][k].rw && mp[j][k].rd != 5'd31 &&
                   mp[j][k].rd == s) begin
                  eh[i] = 1'b1;
                  ed[i*64 +: 64] = mp[j][k].m2r ? mp[j][k].mem : mp[j][k].alu;
               end
            end
         end
         chk($sformatf("d%0d_wb", j + 1),
             256'({valid_o[j], rw_o[j], m2r_o[j], rd_o[j], mem_o[j], alu_o[j], wb_o[j]}),
             256'({l.valid, l.rw, l.m2r, l.rd, l.mem, l.alu, ewb}));
         chk($sformatf("d%0d_fwd", j + 1), 256'({hit_o[j], fdat_o[j]}), 256'({eh, ed}));
         chk($sformatf("d%0d_cnt", j + 1), 256'(cnt_o[j]), 256'(mcnt[j]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic drive(input logic v, rw, m2r, input logic [4:0] rd,
                        input logic [63:0] mem, alu);
      valid_in = v; reg_write_in = rw; mem_to_reg_in = m2r;
      rd_in = rd; mem_data_in = mem; alu_result_in = alu;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      idle();
      src_rd = '0;
      reset  = 1'b1;

      // Vector table for the single-stage pipe
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  64'h0,  64'h0,  1'b0, 5'd0,  64'h0,  32'd0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3,  64'h0,  64'h55, 1'b1, 5'd3,  64'h55, 32'd0};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  64'h0,  64'h0,  1'b0, 5'd0,  64'h0,  32'd1};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9,  64'hAA, 64'h11, 1'b1, 5'd9,  64'hAA, 32'd1};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5,  64'h1,  64'h2,  1'b1, 5'd9,  64'hAA, 32'd1};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6,  64'h3,  64'h4,  1'b0, 5'd0,  64'h0,  32'd2};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 64'h0,  64'h77, 1'b1, 5'd12, 64'h77, 32'd2};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  64'h0,  64'h0,  1'b0, 5'd0,  64'h0,  32'd3};
      for (int t = 0; t < 8; t++) begin
         reset = tbl[t].rst; stall = tbl[t].stl; flush = tbl[t].fls;
         drive(tbl[t].v, tbl[t].rw, tbl[t].m2r, tbl[t].rd, tbl[t].mem, tbl[t].alu);
         tick();
         chk($sformatf("tbl%0d", t), 256'({valid_o[0], rd_o[0], wb_o[0], cnt_o[0]}),
             256'({tbl[t].ev, tbl[t].erd, tbl[t].ewb, tbl[t].ecnt}));
      end

      // DEPTH=3: two stall cycles delay A by two edges; counted once
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 5'd4, 64'h0, 64'hA1);
      tick();
      idle();
      stall = 1'b1;
      tick();
      tick();
      stall = 1'b0;
      tick();
      chk("stall_e4", 256'({valid_o[2], cnt_o[2]}), 256'({1'b0, 32'd0}));
      tick();
      chk("stall_e5", 256'({valid_o[2], rd_o[2], wb_o[2], cnt_o[2]}),
          256'({1'b1, 5'd4, 64'hA1, 32'd0}));
      tick();
      chk("stall_e6", 256'({valid_o[2], cnt_o[2]}), 256'({1'b0, 32'd1}));
      tick();
      chk("stall_e7", 256'(cnt_o[2]), 256'(32'd1));

      // DEPTH=2: youngest writer of r7 wins over older one
      do_reset();
      src_rd = {5'd7, 5'd7};
      drive(1'b1, 1'b1, 1'b1, 5'd7, 64'h20, 64'h99);
      tick();
      drive(1'b1, 1'b1, 1'b0, 5'd7, 64'h33, 64'h10);
      tick();
      idle();
      chk("fwd_young", 256'({hit_o[1], fdat_o[1]}), 256'({2'b11, 64'h10, 64'h10}));

      // XZR is never forwarded; an invalid entry never writes
      do_reset();
      src_rd = {5'd31, 5'd31};
      drive(1'b1, 1'b1, 1'b0, 5'd31, 64'h0, 64'h5);
      tick();
      chk("xzr_wb", 256'({valid_o[0], rd_o[0]}), 256'({1'b1, 5'd31}));
      chk("xzr_fwd", 256'({hit_o[0], fdat_o[0]}), 256'(0));
      src_rd = {5'd6, 5'd6};
      drive(1'b0, 1'b1, 1'b0, 5'd6, 64'h0, 64'h66);
      tick();
      chk("inv_rw", 256'({rw_o[0], hit_o[0], hit_o[1]}), 256'(0));

      // DEPTH=3 full pipe: stall and flush together
      do_reset();
      src_rd = {5'd2, 5'd1};
      for (int n = 1; n <= 3; n++) begin
         drive(1'b1, 1'b1, 1'b0, 5'(n), 64'h0, 64'(n * 16));
         tick();
      end
      idle();
      chk("sf_pre", 256'({valid_o[2], hit_o[2], cnt_o[2]}), 256'({1'b1, 2'b11, 32'd0}));
      stall = 1'b1; flush = 1'b1;
      tick();
      idle();
      chk("sf_post", 256'({valid_o[2], hit_o[2], cnt_o[2]}), 256'({1'b0, 2'b00, 32'd1}));

      // DEPTH=2: reset mid-stream with count at 9
      do_reset();
      src_rd = {5'd8, 5'd8};
      for (int n = 0; n < 11; n++) begin
         drive(1'b1, 1'b1, 1'b0, 5'd8, 64'h0, 64'(n + 1));
         tick();
      end
      chk("rst_pre", 256'({valid_o[1], hit_o[1], cnt_o[1]}), 256'({1'b1, 2'b11, 32'd9}));
      reset = 1'b1;
      tick();
      idle();
      chk("rst_out", 256'({valid_o[1], rw_o[1], m2r_o[1], rd_o[1], mem_o[1], alu_o[1], wb_o[1]}), 256'(0));
      chk("rst_fwd", 256'({hit_o[1], fdat_o[1], cnt_o[1]}), 256'(0));

      // Randomised traffic against the model
      for (int c = 0; c < 400; c++) begin
         logic [3:0] r;
         reset = ($urandom_range(0, 99) < 2);
         stall = ($urandom_range(0, 99) < 20);
         flush = ($urandom_range(0, 99) < 6);
         r = 4'($urandom_range(0, 8));
         drive(1'($urandom), 1'($urandom), 1'($urandom), (r == 4'd8) ? 5'd31 : 5'(r),
               {$urandom, $urandom}, {$urandom, $urandom});
         src_rd = {5'($urandom_range(0, 8)), 5'($urandom_range(0, 8))};
         if (src_rd[4:0] == 5'd8) src_rd[4:0] = 5'd31;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/wb_pipe_fwd.md
# wb_pipe_fwd

Parametrised MEM/WB pipeline register for the pipelined CPU. Carries write-back control and data through DEPTH register stages with stall/flush, and presents the write-back result. Provides NSRC forwarding lookups that return the youngest in-flight writer of a requested register. Replaces the fixed one-stage MEM/WB register, including its separate forwarding copies, and counts retired entries.

## Interface
- DEPTH, 1: number of register stages between MEM and WB; legal 1..4.
- DATA_W, 64: width of the ALU result and memory data.
- REG_W, 5: register-number width.
- NSRC, 2: number of forwarding lookup ports.
- CNT_W, 32: retire counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; all state cleared on the rising edge while high
- stall  in  1  hold all stages
- flush  in  1  invalidate all stages
- valid_in  in  1  MEM-stage entry is real
- reg_write_in, mem_to_reg_in  in  1 each  MEM-stage control
- rd_in  in  REG_W  destination register
- mem_data_in, alu_result_in  in  DATA_W each  MEM-stage data
- valid_wb, reg_write_wb, mem_to_reg_wb  out  1 each  last-stage control
- rd_wb  out  REG_W  last-stage destination
- mem_data_wb, alu_result_wb  out  DATA_W each  last-stage raw data
- wb_data  out  DATA_W  mem_to_reg_wb ? mem_data_wb : alu_result_wb
- src_rd  in  NSRC×REG_W  lookup register numbers
- fwd_hit  out  NSRC  lookup matched
- fwd_data  out  NSRC×DATA_W  forwarded value; 0 on miss
- retire_cnt  out  CNT_W  entries retired since reset

## Operation
- Stage entry fields: valid, reg_write, mem_to_reg, rd, mem_data, alu_result. Stage 0 is youngest. Stage DEPTH-1 drives the *_wb outputs.
- Update priority on each rising edge:
  - reset: every field of every stage goes to 0, and retire_cnt goes to 0.
  - flush: every stage gets valid=0, reg_write=0, and all other fields 0.
  - stall: every stage holds.
  - Otherwise the pipe advances: stage 0 loads the inputs, and stage k loads stage k-1.
- Stage 0 captures reg_write_in & valid_in. An invalid entry never carries reg_write=1.
- Forwarding, per port i:
  - A stage is eligible when it has valid & reg_write, rd ≠ 31 (XZR), and rd == src_rd[i].
  - fwd_hit[i] is 1 if any stage is eligible.
  - fwd_data[i] is the selected data (mem or alu per that stage's mem_to_reg) of the lowest-index eligible stage.
  - Lookup is combinational on current stage contents. Inputs in the MEM stage are not searched.
- retire_cnt increments when valid_wb & (!stall | flush). The last-stage entry commits this cycle regardless of flush. A stalled entry is counted once, on the cycle it leaves. The counter wraps at 2^CNT_W.

## Timing
- Latency from input to *_wb is DEPTH rising edges with no stall.
- Each stall cycle adds exactly one cycle.
- After reset, every output is 0, including wb_data, fwd_hit, fwd_data and retire_cnt.
- flush and stall in the same cycle: flush wins, and the next cycle shows all stages empty.
- flush takes effect on the edge: on that same edge the current last stage is counted (if valid), then cleared.
- Reset asserted mid-stream discards all in-flight entries. No count is made on the reset edge.
- wb_data, fwd_hit and fwd_data are combinational from registered state. There are no combinational paths from stall, flush or data inputs to any output, except src_rd→fwd_*.

## Structure
- Package wb_pipe_pkg holds:
  - the entry struct typedef, parametrised via localparams DATA_W_DEF and REG_W_DEF;
  - the XZR constant ZERO_REG = 5'd31;
  - the function sel_data(entry) returning the mux result.
- Sub-module wb_pipe_stage: one entry register with reset/flush/stall/load priority. It is instantiated DEPTH times via generate.
- The lookup priority encoder and retire counter live in the top level.

## Test plan
- DEPTH=1, no stall: valid_in=1, reg_write_in=1, rd_in=3, alu_result_in=0x55, mem_to_reg_in=0. After 1 edge: rd_wb=3, wb_data=0x55, and retire_cnt increments to 1 on the following edge.
- DEPTH=3, stall: push A(rd=4), then assert stall for 2 cycles. A reaches WB at edge 5 (3+2). retire_cnt increments exactly once for A.
- DEPTH=2: stage0 holds rd=7 alu=0x10, and stage1 holds rd=7 mem_to_reg=1 mem=0x20. Set src_rd[0]=7 → fwd_hit[0]=1, fwd_data[0]=0x10.
- Lookup src_rd=31 with a valid writer to rd=31 in pipe → fwd_hit=0, fwd_data=0. Same for valid_in=0 with reg_write_in=1: the stored reg_write is 0 and there is no hit.
- DEPTH=3 with 3 valid entries in flight: assert stall and flush together. Next cycle all valid=0 and fwd_hit=0, and retire_cnt increments by 1 (the last-stage entry).
- Reset mid-stream with 2 valid entries and retire_cnt=9 → next cycle every output is 0.
